mdu_iter: RTL and testbench

- Parametrised successor to the pipeline's fixed-latency multiply/divide unit.
- Sits in the E stage beside the ALU and owns the HI/LO registers.
- Width, multiply latency and divide latency are set by parameters.
- Adds what the previous unit lacks:
  - a `cancel` input so an interrupt or exception flush can kill an E-stage MDU instruction;
  - defined divide-by-zero and signed-overflow results;
  - a `pending` output for the hazard controller.

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/mdu_lat_cnt.sv | 29 ++
 rtl/mdu_iter.sv | 137 +++++++++++++
 tb/tb_mdu_iter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, op classification and AO-mux select constants for the E-stage MDU.
// MDU_MADD_EN adds the accumulate ops (7-10) to the multiply/divide class.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [1:0] FROM_ALU = 2'd0;
    localparam logic [1:0] FROM_HI  = 2'd1;
    localparam logic [1:0] FROM_LO  = 2'd2;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Ops that occupy the unit for a latency window and write both HI and LO.
    function automatic logic is_muldiv(input logic [3:0] op);
        logic md;
        md = (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`ifdef MDU_MADD_EN
        md = md || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return md;
    endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Latency down-counter: loads the op latency on accept, counts to zero, flags the final cycle.
module mdu_lat_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] lat,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);
    // The edge ending a count of 1 is the one that retires the operation.
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/mdu_iter.sv
// E-stage multiply/divide unit owning HI/LO, with parametrised latency, cancel and pending.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             start,
    input  logic             cancel,
    output logic             busy,
    output logic             pending,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic             sgn);
        logic signed [2*WIDTH-1:0] xs;
        logic signed [2*WIDTH-1:0] ys;
        xs = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ys = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xs * ys;
    endfunction

    // Returns {remainder, quotient}; zero divisor and signed overflow have fixed results.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y,
                                                    input logic             sgn);
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        xs = x;
        ys = y;
        q  = '0;
        r  = '0;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (sgn && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == '1)) begin
            q = x;
            r = '0;
        end else if (sgn) begin
            q = xs / ys;
            r = xs % ys;
        end else begin
            q = x / y;
            r = x % y;
        end
        return {r, q};
    endfunction

    logic             accept_p0;
    logic             md_p0;
    logic [CNT_W-1:0] lat_p0;
    logic             done_p1;

    logic [WIDTH-1:0]   a_p1;
    logic [WIDTH-1:0]   b_p1;
    logic [3:0]         op_p1;
    logic [2*WIDTH-1:0] res_p1;
`ifdef MDU_MADD_EN
    logic [2*WIDTH-1:0] acc_p1;
`endif

    // ---- p0: accept decision ----
    assign accept_p0 = start & ~cancel & ~busy;
    assign md_p0     = is_muldiv(op);
    assign pending   = busy | (start & ~cancel & md_p0);
    assign lat_p0    = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    mdu_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (accept_p0 & md_p0),
        .lat   (lat_p0),
        .busy  (busy),
        .done  (done_p1)
    );

    // ---- p1: operands held for the whole busy window ----
    always_ff @(posedge clk) begin
        if (accept_p0 && md_p0) begin
            a_p1   <= a;
            b_p1   <= b;
            op_p1  <= op;
`ifdef MDU_MADD_EN
            acc_p1 <= {hi, lo};
`endif
        end
    end

    always_comb begin
        res_p1 = {hi, lo};
        case (op_p1)
            OP_MULT:  res_p1 = mul_full(a_p1, b_p1, 1'b1);
            OP_MULTU: res_p1 = mul_full(a_p1, b_p1, 1'b0);
            OP_DIV:   res_p1 = div_full(a_p1, b_p1, 1'b1);
            OP_DIVU:  res_p1 = div_full(a_p1, b_p1, 1'b0);
`ifdef MDU_MADD_EN
            OP_MADD:  res_p1 = acc_p1 + mul_full(a_p1, b_p1, 1'b1);
            OP_MADDU: res_p1 = acc_p1 + mul_full(a_p1, b_p1, 1'b0);
            OP_MSUB:  res_p1 = acc_p1 - mul_full(a_p1, b_p1, 1'b1);
            OP_MSUBU: res_p1 = acc_p1 - mul_full(a_p1, b_p1, 1'b0);
`endif
            default:  res_p1 = {hi, lo};
        endcase
    end

    // ---- HI/LO architectural state ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (done_p1) begin
            hi <= res_p1[2*WIDTH-1:WIDTH];
            lo <= res_p1[WIDTH-1:0];
        end else if (accept_p0) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized self-checking bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

    localparam int W        = 32;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a_i, b_i;
    logic [3:0]    op_i;
    logic          start_i, cancel_i;
    logic          busy, pending;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_hi, m_lo;

    mdu_iter #(
        .WIDTH    (W),
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a_i),
        .b       (b_i),
        .op      (op_i),
        .start   (start_i),
        .cancel  (cancel_i),
        .busy    (busy),
        .pending (pending),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_md(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
        return (o >= 4'd1 && o <= 4'd4);
`endif
    endfunction

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit sgn);
        int xi, yi;
        longint p;
        logic [63:0] ux, uy;
        xi = x;
        yi = y;
        ux = {32'h0, x};
        uy = {32'h0, y};
        if (sgn) begin
            p = longint'(xi) * longint'(yi);
            return p;
        end
        return ux * uy;
    endfunction

    // {hi, lo} after a mult/div-class op.
    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] acc);
        int xi, yi, q, r;
        logic [31:0] uq, ur;
        xi = x;
        yi = y;
        case (o)
            4'd1: return ref_mul(x, y, 1'b1);
            4'd2: return ref_mul(x, y, 1'b0);
            4'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, x};
                q = xi / yi;
                r = xi - q * yi;
                return {r, q};
            end
            4'd4: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                uq = x / y;
                ur = x - uq * y;
                return {ur, uq};
            end
            4'd7:  return acc + ref_mul(x, y, 1'b1);
            4'd8:  return acc + ref_mul(x, y, 1'b0);
            4'd9:  return acc - ref_mul(x, y, 1'b1);
            4'd10: return acc - ref_mul(x, y, 1'b0);
            default: return acc;
        endcase
    endfunction

    // Called just after a negedge with the unit idle; returns just after the negedge
    // of the first idle cycle so the next call can issue back-to-back.
    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit cnc);
        bit md, acc;
        int lat;
        logic [63:0] exp;
        md  = ref_md(o);
        acc = !cnc;
        lat = (o == 4'd3 || o == 4'd4) ? DIV_LAT : MULT_LAT;
        exp = ref_res(o, x, y, {m_hi, m_lo});
        a_i = x; b_i = y; op_i = o; start_i = 1'b1; cancel_i = cnc;
        #1;
        check("pending_issue", pending, (acc && md) ? 1 : 0);
        check("busy_issue", busy, 0);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cancel_i = 1'b0;
        if (acc && md) begin
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                check("busy_window", busy, 1);
                check("pending_window", pending, 1);
                check("hi_hold", hi, m_hi);
                check("lo_hold", lo, m_lo);
                // A start while busy must be ignored.
                if (i < lat) begin
                    op_i = 4'd6; a_i = $urandom; start_i = 1'b1;
                end else begin
                    start_i = 1'b0;
                end
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end else if (acc && o == 4'd5) begin
            m_hi = x;
        end else if (acc && o == 4'd6) begin
            m_lo = x;
        end
        @(negedge clk);
        check("busy_done", busy, 0);
        check("hi_result", hi, m_hi);
        check("lo_result", lo, m_lo);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0] rops [13];
        rops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12, 4'd15};
        reset = 1'b1;
        a_i = '0; b_i = '0; op_i = '0; start_i = 1'b0; cancel_i = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("mult_hi_abs", hi, 32'hFFFF_FFFF);
        check("mult_lo_abs", lo, 32'hFFFF_FFFE);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        check("multu_hi_abs", hi, 32'h1);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_lo_abs", lo, 32'hFFFF_FFFD);
        check("div_hi_abs", hi, 32'hFFFF_FFFF);
        do_op(4'd4, 32'd7, 32'd0, 1'b0);
        check("divu0_lo_abs", lo, 32'hFFFF_FFFF);
        check("divu0_hi_abs", hi, 32'd7);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_lo_abs", lo, 32'h8000_0000);
        check("divovf_hi_abs", hi, 32'h0);
        do_op(4'd1, 32'd3, 32'd4, 1'b1);
        do_op(4'd6, 32'h1234, 32'd0, 1'b1);
        do_op(4'd6, 32'h1234, 32'd0, 1'b0);
        check("mtlo_abs", lo, 32'h1234);

`ifdef MDU_MADD_EN
        do_op(4'd5, 32'h0, 32'd0, 1'b0);
        do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(4'd8, 32'd1, 32'd1, 1'b0);
        check("maddu_hi_abs", hi, 32'h1);
        check("maddu_lo_abs", lo, 32'h0);
`else
        do_op(4'd8, 32'd1, 32'd1, 1'b0);
`endif

        // Reset in the 4th busy cycle of a divide.
        do_op(4'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
        a_i = 32'd100; b_i = 32'd7; op_i = 4'd3; start_i = 1'b1; cancel_i = 1'b0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        do_op(4'd3, 32'd100, 32'd7, 1'b0);

        for (int n = 0; n < 40; n++) begin
            do_op(rops[$urandom_range(0, 12)], pick_val(), pick_val(),
                  ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
